// File: rtl/inst_fetch_if.sv
// Fetch-side SRAM-like bus controller: issues one instruction read at a time for pcF
// and holds the returned instruction until the pipeline consumes it.
module inst_fetch_if #(
  parameter int          AW  = 32,
  parameter int          DW  = 32,
  parameter logic [DW-1:0] NOP = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pcF,
  input  logic          stall_i,
  input  logic          flush_i,
  output logic [DW-1:0] instrF,
  output logic          stallreq_from_if,
  output logic          is_clear,
  output logic          i_data_ok,
  output logic [AW-1:0] IF_pc,
  output logic          inst_req,
  output logic          inst_wr,
  output logic [1:0]    inst_size,
  output logic [AW-1:0] inst_addr,
  input  logic          inst_addr_ok,
  input  logic          inst_data_ok,
  input  logic [DW-1:0] inst_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          dataOk_q, dataOk_d;
  logic          misaligned;

  assign misaligned = (pcF[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      pc_q     <= '0;
      dataOk_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      pc_q     <= pc_d;
      dataOk_q <= dataOk_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // A misaligned PC never reaches the bus; NOP is held while the datapath traps.
        if (misaligned) begin
          pc_d    = pcF;
          buf_d   = NOP;
          state_d = HOLD;
        end else if (inst_addr_ok) begin
          if (flush_i) begin
            state_d = CLEAR;
          end else begin
            pc_d    = pcF;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          if (flush_i) begin
            state_d = REQ;
          end else begin
            buf_d   = inst_rdata;
            state_d = HOLD;
          end
        end else if (flush_i) begin
          state_d = CLEAR;
        end
      end
      HOLD: begin
        if (flush_i || !stall_i) state_d = REQ;
      end
      CLEAR: begin
        if (inst_data_ok) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    dataOk_d = (state_d == HOLD) && (state_q != HOLD);
  end

  assign instrF           = buf_q;
  assign IF_pc            = pc_q;
  assign i_data_ok        = dataOk_q;
  assign inst_req         = (state_q == REQ) && !misaligned;
  assign inst_wr          = 1'b0;
  assign inst_size        = 2'b10;
  assign inst_addr        = pcF;
  assign stallreq_from_if = (state_q != HOLD);
  assign is_clear         = (state_q == CLEAR);

endmodule

// File: tb/tb_inst_fetch_if.sv
// Directed bench for inst_fetch_if: the bench plays the bus slave and pipeline
// cycle by cycle and compares every output against hand-computed values.
module tb_inst_fetch_if;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] instrF;
  logic        stallreq_from_if;
  logic        is_clear;
  logic        i_data_ok;
  logic [31:0] IF_pc;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  int total = 0;
  int bad   = 0;

  inst_fetch_if dut (
    .clk              (clk),
    .rst              (rst),
    .pcF              (pcF),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .instrF           (instrF),
    .stallreq_from_if (stallreq_from_if),
    .is_clear         (is_clear),
    .i_data_ok        (i_data_ok),
    .IF_pc            (IF_pc),
    .inst_req         (inst_req),
    .inst_wr          (inst_wr),
    .inst_size        (inst_size),
    .inst_addr        (inst_addr),
    .inst_addr_ok     (inst_addr_ok),
    .inst_data_ok     (inst_data_ok),
    .inst_rdata       (inst_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic addrOk, input logic dataOk, input logic flush,
                               input logic stall, input logic [31:0] pc, input logic [31:0] rdata);
    inst_addr_ok = addrOk;
    inst_data_ok = dataOk;
    flush_i      = flush;
    stall_i      = stall;
    pcF          = pc;
    inst_rdata   = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0000, 32'h0);
    #1 rst = 1'b0;
    #2;
    checkOutput("rst_req",      {31'd0, inst_req}, 32'd0);
    checkOutput("rst_stallreq", {31'd0, stallreq_from_if}, 32'd1);
    checkOutput("rst_clear",    {31'd0, is_clear}, 32'd0);
    checkOutput("rst_instr",    instrF, 32'h0);
    checkOutput("rst_pc",       IF_pc, 32'h0);
    checkOutput("rst_dok",      {31'd0, i_data_ok}, 32'd0);
    checkOutput("wr_tie",       {31'd0, inst_wr}, 32'd0);
    checkOutput("size_tie",     {30'd0, inst_size}, 32'd2);
    tick();
    tick();
    rst = 1'b1;

    // basic fetch: IDLE, REQ, WAIT, HOLD
    applyStimulus(1, 0, 0, 1, 32'hBFC0_0000, 32'h0);
    checkOutput("idle_req", {31'd0, inst_req}, 32'd0);
    tick();
    checkOutput("req_req",  {31'd0, inst_req}, 32'd1);
    checkOutput("req_addr", inst_addr, 32'hBFC0_0000);
    tick();
    applyStimulus(0, 1, 0, 1, 32'hBFC0_0000, 32'h2408_0001);
    checkOutput("wait_req",      {31'd0, inst_req}, 32'd0);
    checkOutput("wait_stallreq", {31'd0, stallreq_from_if}, 32'd1);
    checkOutput("wait_dok",      {31'd0, i_data_ok}, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0004, 32'h0);
    checkOutput("hold_instr",    instrF, 32'h2408_0001);
    checkOutput("hold_pc",       IF_pc, 32'hBFC0_0000);
    checkOutput("hold_dok",      {31'd0, i_data_ok}, 32'd1);
    checkOutput("hold_stallreq", {31'd0, stallreq_from_if}, 32'd0);

    // hold under stall
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_instr", instrF, 32'h2408_0001);
      checkOutput("stall_pc",    IF_pc, 32'hBFC0_0000);
      checkOutput("stall_req",   {31'd0, inst_req}, 32'd0);
      checkOutput("stall_dok",   {31'd0, i_data_ok}, 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 32'hBFC0_0004, 32'h0);
    tick();
    applyStimulus(1, 0, 0, 1, 32'hBFC0_0004, 32'h0);
    checkOutput("next_req",      {31'd0, inst_req}, 32'd1);
    checkOutput("next_addr",     inst_addr, 32'hBFC0_0004);
    checkOutput("next_stallreq", {31'd0, stallreq_from_if}, 32'd1);

    // flush during WAIT with a slow slave
    tick();
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0004, 32'h0);
    checkOutput("fw_pc", IF_pc, 32'hBFC0_0004);
    tick();
    checkOutput("fw_wait_clear", {31'd0, is_clear}, 32'd0);
    applyStimulus(0, 0, 1, 1, 32'hBFC0_0380, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0380, 32'h0);
    checkOutput("fw_clear1", {31'd0, is_clear}, 32'd1);
    checkOutput("fw_req1",   {31'd0, inst_req}, 32'd0);
    tick();
    checkOutput("fw_clear2", {31'd0, is_clear}, 32'd1);
    applyStimulus(0, 1, 0, 1, 32'hBFC0_0380, 32'hDEAD_BEEF);
    checkOutput("fw_clear3",   {31'd0, is_clear}, 32'd1);
    checkOutput("fw_stallreq", {31'd0, stallreq_from_if}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0380, 32'h0);
    checkOutput("fw_clear_done", {31'd0, is_clear}, 32'd0);
    checkOutput("fw_req",        {31'd0, inst_req}, 32'd1);
    checkOutput("fw_addr",       inst_addr, 32'hBFC0_0380);
    checkOutput("fw_instr",      instrF, 32'h2408_0001);

    // flush coincident with returned data
    applyStimulus(1, 0, 0, 1, 32'hBFC0_0380, 32'h0);
    tick();
    checkOutput("fc_pc", IF_pc, 32'hBFC0_0380);
    applyStimulus(0, 1, 1, 1, 32'hBFC0_0400, 32'h1111_1111);
    tick();
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0400, 32'h0);
    checkOutput("fc_req",      {31'd0, inst_req}, 32'd1);
    checkOutput("fc_addr",     inst_addr, 32'hBFC0_0400);
    checkOutput("fc_dok",      {31'd0, i_data_ok}, 32'd0);
    checkOutput("fc_stallreq", {31'd0, stallreq_from_if}, 32'd1);
    checkOutput("fc_instr",    instrF, 32'h2408_0001);

    // misaligned PC
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0002, 32'h0);
    checkOutput("mis_req", {31'd0, inst_req}, 32'd0);
    tick();
    checkOutput("mis_instr",    instrF, 32'h0000_0000);
    checkOutput("mis_pc",       IF_pc, 32'hBFC0_0002);
    checkOutput("mis_dok",      {31'd0, i_data_ok}, 32'd1);
    checkOutput("mis_stallreq", {31'd0, stallreq_from_if}, 32'd0);

    // reset in the middle of a transaction
    applyStimulus(0, 0, 0, 0, 32'hBFC0_0008, 32'h0);
    tick();
    applyStimulus(1, 0, 0, 1, 32'hBFC0_0008, 32'h0);
    checkOutput("mr_req", {31'd0, inst_req}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 1, 32'hBFC0_0008, 32'h0);
    checkOutput("mr_wait_pc", IF_pc, 32'hBFC0_0008);
    #1 rst = 1'b0;
    #1;
    checkOutput("mr_rst_stallreq", {31'd0, stallreq_from_if}, 32'd1);
    checkOutput("mr_rst_instr",    instrF, 32'h0);
    checkOutput("mr_rst_pc",       IF_pc, 32'h0);
    checkOutput("mr_rst_clear",    {31'd0, is_clear}, 32'd0);
    checkOutput("mr_rst_dok",      {31'd0, i_data_ok}, 32'd0);
    tick();
    rst = 1'b1;
    applyStimulus(1, 0, 0, 1, 32'hBFC0_0008, 32'h0);
    checkOutput("mr_idle_req", {31'd0, inst_req}, 32'd0);
    tick();
    checkOutput("mr_req_again", {31'd0, inst_req}, 32'd1);
    checkOutput("mr_addr",      inst_addr, 32'hBFC0_0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
